// File: rtl/rim_pkg.sv
// Shared types and helpers for the rat-in-maze solver.
package rim_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SOLVE,
    S_OUTPUT,
    S_FAIL
  } state_e;

  // Grid coordinate, wide enough for the largest legal grid (16 x 16).
  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } coord_t;

  // Width of a row/column index for an n x n grid, never less than one bit.
  function automatic int CW(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

  // Number of cells on any down/right path from corner to corner.
  function automatic int PATH_LEN(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/rim_branch_stack.sv
// LIFO of branch points {row, col, k} used by the depth-first search.
module rim_branch_stack #(
  parameter int DEPTH = 14,
  parameter int EW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [EW-1:0] push_data_i,
  output logic [EW-1:0] top_o,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH + 1);

  logic [PW-1:0] ptr_q;
  logic [EW-1:0] mem_q [0:(1<<PW)-1];

  // Stack pointer: cleared per frame, grows on push, shrinks on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (clr_i) begin
      ptr_q <= '0;
    end else if (push_i && (ptr_q != PW'(DEPTH))) begin
      ptr_q <= ptr_q + PW'(1);
    end else if (pop_i && (ptr_q != '0)) begin
      ptr_q <= ptr_q - PW'(1);
    end
  end

  // Entry storage; contents above the pointer are don't-care.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i && (ptr_q != PW'(DEPTH))) begin
      mem_q[ptr_q] <= push_data_i;
    end
  end

  assign top_o   = mem_q[ptr_q - PW'(1)];
  assign empty_o = (ptr_q == '0);

endmodule

// File: rtl/rim_solver_p.sv
// Rat-in-maze solver for an N x N grid: load rows, depth-first search with
// down/right moves, then stream the path or a no-path beat.
// Optional macro RIM_SOLVE_CNT_EN adds solve_cnt_o (cycles spent in SOLVE).
module rim_solver_p
  import rim_pkg::*;
#(
  parameter int N        = 8,
  parameter int DIR_PRIO = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  input  logic [N-1:0]       maze_i,
  output logic               busy_o,
  output logic               out_valid_o,
  output logic [CW(N)-1:0]   out_row_o,
  output logic [CW(N)-1:0]   out_col_o,
  output logic               out_last_o,
`ifdef RIM_SOLVE_CNT_EN
  output logic [15:0]        solve_cnt_o,
`endif
  output logic               no_path_o
);

  localparam int RCW  = CW(N);
  localparam int PLEN = PATH_LEN(N);
  localparam int KW   = $clog2(PLEN);
  localparam int EW   = 2 * RCW + KW;
  localparam logic [RCW-1:0] LASTRC = RCW'(N - 1);
  localparam logic [KW-1:0]  LASTK  = KW'(PLEN - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    map_q [N];
  coord_t          path_q [PLEN];
  logic [RCW-1:0]  r_q, c_q, rowCnt_q, rowP1, colP1;
  logic [KW-1:0]   k_q, outIdx_q;
  logic            startChk_q;
  logic            curOpen, canDown, canRight, goDown, goRight;
  logic            stkPush, stkPop, recordCell, frameStart;
  logic [EW-1:0]   stkTop;
  logic            stkEmpty;
  logic [RCW-1:0]  popR, popC;
  logic [KW-1:0]   popK;

  assign rowP1      = r_q + RCW'(1);
  assign colP1      = c_q + RCW'(1);
  assign frameStart = (state_q == S_IDLE) && in_valid_i;
  assign {popR, popC, popK} = stkTop;

  rim_branch_stack #(
    .DEPTH (2 * N - 2),
    .EW    (EW)
  ) u_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (frameStart),
    .push_i      (stkPush),
    .pop_i       (stkPop),
    .push_data_i ({r_q, c_q, k_q}),
    .top_o       (stkTop),
    .empty_o     (stkEmpty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, search move selection and result outputs.
  always_comb begin
    state_d     = state_q;
    curOpen     = map_q[r_q][c_q];
    canDown     = (r_q != LASTRC) && map_q[rowP1][c_q];
    canRight    = (c_q != LASTRC) && map_q[r_q][colP1];
    goDown      = 1'b0;
    goRight     = 1'b0;
    stkPush     = 1'b0;
    stkPop      = 1'b0;
    recordCell  = 1'b0;
    busy_o      = (state_q != S_IDLE);
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    no_path_o   = 1'b0;
    out_row_o   = '0;
    out_col_o   = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) state_d = (N == 1) ? S_SOLVE : S_LOAD;
      end
      S_LOAD: begin
        if (!in_valid_i)               state_d = S_IDLE;
        else if (rowCnt_q == LASTRC)   state_d = S_SOLVE;
      end
      S_SOLVE: begin
        if (startChk_q && !curOpen) begin
          state_d = S_FAIL;
        end else begin
          recordCell = 1'b1;
          if ((r_q == LASTRC) && (c_q == LASTRC)) begin
            state_d = S_OUTPUT;
          end else if (canDown && canRight) begin
            stkPush = 1'b1;
            if (DIR_PRIO == 0) goRight = 1'b1;
            else               goDown  = 1'b1;
          end else if (canRight) begin
            goRight = 1'b1;
          end else if (canDown) begin
            goDown = 1'b1;
          end else if (!stkEmpty) begin
            stkPop = 1'b1;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_OUTPUT: begin
        out_valid_o = 1'b1;
        out_row_o   = RCW'(path_q[outIdx_q].row);
        out_col_o   = RCW'(path_q[outIdx_q].col);
        out_last_o  = (outIdx_q == LASTK);
        if (outIdx_q == LASTK) state_d = S_IDLE;
      end
      S_FAIL: begin
        out_valid_o = 1'b1;
        out_last_o  = 1'b1;
        no_path_o   = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Maze map, search position, recorded path and output beat index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) map_q[i] <= '0;
      for (int i = 0; i < PLEN; i++) path_q[i] <= '0;
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      rowCnt_q   <= '0;
      outIdx_q   <= '0;
      startChk_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            map_q[0]   <= maze_i;
            rowCnt_q   <= RCW'(1);
            r_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
            startChk_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_valid_i) begin
            map_q[rowCnt_q] <= maze_i;
            rowCnt_q        <= rowCnt_q + RCW'(1);
          end
        end
        S_SOLVE: begin
          startChk_q <= 1'b0;
          if (recordCell) begin
            path_q[k_q]       <= '{row: 4'(r_q), col: 4'(c_q)};
            map_q[r_q][c_q]   <= 1'b0;
          end
          if (goDown) begin
            r_q <= rowP1;
            k_q <= k_q + KW'(1);
          end else if (goRight) begin
            c_q <= colP1;
            k_q <= k_q + KW'(1);
          end else if (stkPop) begin
            r_q <= popR;
            c_q <= popC;
            k_q <= popK;
          end
          outIdx_q <= '0;
        end
        S_OUTPUT: begin
          outIdx_q <= outIdx_q + KW'(1);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef RIM_SOLVE_CNT_EN
  logic [15:0] runCnt_q, solveCnt_q;

  // Count SOLVE cycles and publish the total when the search finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runCnt_q   <= '0;
      solveCnt_q <= '0;
    end else if (frameStart) begin
      runCnt_q   <= '0;
      solveCnt_q <= '0;
    end else if (state_q == S_SOLVE) begin
      runCnt_q <= runCnt_q + 16'd1;
      if (state_d != S_SOLVE) solveCnt_q <= runCnt_q + 16'd1;
    end
  end

  assign solve_cnt_o = solveCnt_q;
`endif

endmodule

// File: tb/tb_rim_solver_p.sv
// Self-checking bench for rim_solver_p: a 4x4 right-first instance and an
// 8x8 down-first instance, checked against a reachability-based path model.
module tb_rim_solver_p;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       inValid4 = 1'b0, inValid8 = 1'b0;
  logic [3:0] maze4 = 4'd0;
  logic [7:0] maze8 = 8'd0;
  logic       busy4, oValid4, oLast4, noPath4;
  logic [1:0] oRow4, oCol4;
  logic       busy8, oValid8, oLast8, noPath8;
  logic [2:0] oRow8, oCol8;
`ifdef RIM_SOLVE_CNT_EN
  logic [15:0] cnt4, cnt8;
`endif

  int errors = 0;
  int checks = 0;
  int sel = 4;

  logic [15:0] mzRows [16];
  int  expRow [32];
  int  expCol [32];
  int  expLen;
  bit  expNoPath;
  int  capRow [64];
  int  capCol [64];
  bit  capLast [64];
  bit  capNp [64];
  int  capCnt;
  bit  capGap, capTimeout;

  logic mValid, mLast, mNp, mBusy;
  int   mRow, mCol;

  always #5 clk = ~clk;

  rim_solver_p #(.N(4), .DIR_PRIO(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(inValid4), .maze_i(maze4),
    .busy_o(busy4), .out_valid_o(oValid4), .out_row_o(oRow4), .out_col_o(oCol4),
    .out_last_o(oLast4),
`ifdef RIM_SOLVE_CNT_EN
    .solve_cnt_o(cnt4),
`endif
    .no_path_o(noPath4)
  );

  rim_solver_p #(.N(8), .DIR_PRIO(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(inValid8), .maze_i(maze8),
    .busy_o(busy8), .out_valid_o(oValid8), .out_row_o(oRow8), .out_col_o(oCol8),
    .out_last_o(oLast8),
`ifdef RIM_SOLVE_CNT_EN
    .solve_cnt_o(cnt8),
`endif
    .no_path_o(noPath8)
  );

  // Route the selected instance's outputs to common observation signals.
  always_comb begin
    if (sel == 8) begin
      mValid = oValid8; mLast = oLast8; mNp = noPath8; mBusy = busy8;
      mRow = int'(oRow8); mCol = int'(oCol8);
    end else begin
      mValid = oValid4; mLast = oLast4; mNp = noPath4; mBusy = busy4;
      mRow = int'(oRow4); mCol = int'(oCol4);
    end
  end

  // Expected path: a cell is useful iff it is open and can reach the goal;
  // the search follows the preferred useful neighbour at every step.
  task automatic computeExpected(input int n, input int prio);
    bit reach [16][16];
    bit downOk, rightOk;
    int r, c;
    for (int rr = n - 1; rr >= 0; rr--) begin
      for (int cc = n - 1; cc >= 0; cc--) begin
        if (rr == n - 1 && cc == n - 1) reach[rr][cc] = mzRows[rr][cc];
        else begin
          downOk  = (rr < n - 1) ? reach[rr + 1][cc] : 1'b0;
          rightOk = (cc < n - 1) ? reach[rr][cc + 1] : 1'b0;
          reach[rr][cc] = mzRows[rr][cc] && (downOk || rightOk);
        end
      end
    end
    expNoPath = !reach[0][0];
    expLen = 0;
    if (!expNoPath) begin
      r = 0; c = 0;
      forever begin
        expRow[expLen] = r; expCol[expLen] = c; expLen++;
        if (r == n - 1 && c == n - 1) break;
        downOk  = (r < n - 1) ? reach[r + 1][c] : 1'b0;
        rightOk = (c < n - 1) ? reach[r][c + 1] : 1'b0;
        if (prio == 1) begin
          if (downOk) r++; else c++;
        end else begin
          if (rightOk) c++; else r++;
        end
      end
    end
  endtask

  // Drive the first nRows of mzRows into the selected instance, one per cycle.
  task automatic applyStimulus(input int nRows);
    @(posedge clk); #1;
    for (int i = 0; i < nRows; i++) begin
      if (sel == 8) begin inValid8 = 1'b1; maze8 = mzRows[i][7:0]; end
      else          begin inValid4 = 1'b1; maze4 = mzRows[i][3:0]; end
      @(posedge clk); #1;
    end
    inValid4 = 1'b0;
    inValid8 = 1'b0;
  endtask

  // Capture the result beats of the selected instance, bounded by budget.
  task automatic collect(input int budget);
    bit started = 1'b0;
    capCnt = 0; capGap = 1'b0; capTimeout = 1'b1;
    for (int i = 0; i < 64; i++) begin
      capRow[i] = -1; capCol[i] = -1; capLast[i] = 1'b0; capNp[i] = 1'b0;
    end
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mValid) begin
        started = 1'b1;
        if (capCnt < 64) begin
          capRow[capCnt] = mRow; capCol[capCnt] = mCol;
          capLast[capCnt] = mLast; capNp[capCnt] = mNp;
        end
        capCnt++;
        if (mLast) begin capTimeout = 1'b0; break; end
      end else if (started) begin
        capGap = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy4, oValid4, oLast4, noPath4} !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl4: got %b required 0000", {busy4, oValid4, oLast4, noPath4});
    end
    checks++;
    if ({oRow4, oCol4} !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_rc4: got %b required 0000", {oRow4, oCol4});
    end
    checks++;
    if ({busy8, oValid8, oLast8, noPath8, oRow8, oCol8} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_all8: got %b required 0", {busy8, oValid8, oLast8, noPath8, oRow8, oCol8});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_all_open();
    int eR[7] = '{0, 0, 0, 0, 1, 2, 3};
    int eC[7] = '{0, 1, 2, 3, 3, 3, 3};
    sel = 4;
    for (int i = 0; i < 16; i++) mzRows[i] = 16'h000F;
    applyStimulus(4);
    collect(200);
    checks++;
    if (capTimeout || capGap || capCnt != 7) begin
      errors++;
      $display("[TB] FAIL allopen_len: got beats=%0d timeout=%0d gap=%0d required 7 0 0", capCnt, capTimeout, capGap);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (capRow[i] !== eR[i] || capCol[i] !== eC[i] || capNp[i] !== 1'b0 || capLast[i] !== (i == 6)) begin
        errors++;
        $display("[TB] FAIL allopen_beat%0d: got (%0d,%0d) np=%0d last=%0d required (%0d,%0d) np=0 last=%0d",
                 i, capRow[i], capCol[i], capNp[i], capLast[i], eR[i], eC[i], (i == 6));
      end
    end
    @(negedge clk);
    checks++;
    if (mBusy !== 1'b0 || mValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL allopen_idle: got busy=%0d valid=%0d required 0 0", mBusy, mValid);
    end
  endtask

  task automatic test_backtrack();
    int eR[7] = '{0, 1, 2, 2, 3, 3, 3};
    int eC[7] = '{0, 0, 0, 1, 1, 2, 3};
    sel = 4;
    mzRows[0] = 16'h0007; mzRows[1] = 16'h0001; mzRows[2] = 16'h0003; mzRows[3] = 16'h000E;
    applyStimulus(4);
    collect(200);
    checks++;
    if (capTimeout || capGap || capCnt != 7) begin
      errors++;
      $display("[TB] FAIL backtrack_len: got beats=%0d timeout=%0d gap=%0d required 7 0 0", capCnt, capTimeout, capGap);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (capRow[i] !== eR[i] || capCol[i] !== eC[i] || capNp[i] !== 1'b0 || capLast[i] !== (i == 6)) begin
        errors++;
        $display("[TB] FAIL backtrack_beat%0d: got (%0d,%0d) np=%0d last=%0d required (%0d,%0d) np=0 last=%0d",
                 i, capRow[i], capCol[i], capNp[i], capLast[i], eR[i], eC[i], (i == 6));
      end
    end
`ifdef RIM_SOLVE_CNT_EN
    checks++;
    if (cnt4 !== 16'd10) begin
      errors++;
      $display("[TB] FAIL backtrack_cnt: got %0d required 10", cnt4);
    end
`endif
  endtask

  task automatic test_no_path();
    logic [3:0] tbl [2][4] = '{'{4'b0001, 4'b0000, 4'b1111, 4'b1111},
                               '{4'b1110, 4'b1111, 4'b1111, 4'b1111}};
    sel = 4;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 4; i++) mzRows[i] = {12'd0, tbl[t][i]};
      applyStimulus(4);
      collect(200);
      checks++;
      if (capTimeout || capCnt != 1 || capNp[0] !== 1'b1 || capLast[0] !== 1'b1 ||
          capRow[0] != 0 || capCol[0] != 0) begin
        errors++;
        $display("[TB] FAIL nopath%0d: got beats=%0d np=%0d last=%0d rc=(%0d,%0d) required 1 1 1 (0,0)",
                 t, capCnt, capNp[0], capLast[0], capRow[0], capCol[0]);
      end
      @(negedge clk);
      checks++;
      if (mBusy !== 1'b0 || mValid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL nopath%0d_idle: got busy=%0d valid=%0d required 0 0", t, mBusy, mValid);
      end
    end
  endtask

  task automatic test_abort();
    sel = 4;
    for (int i = 0; i < 16; i++) mzRows[i] = 16'h000F;
    applyStimulus(2);
    collect(40);
    checks++;
    if (capCnt != 0 || mBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort: got beats=%0d busy=%0d required 0 0", capCnt, mBusy);
    end
    mzRows[0] = 16'h0007; mzRows[1] = 16'h0001; mzRows[2] = 16'h0003; mzRows[3] = 16'h000E;
    computeExpected(4, 0);
    applyStimulus(4);
    collect(200);
    checks++;
    if (capTimeout || capCnt != 7 || capRow[3] != 2 || capCol[3] != 1 || capLast[6] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_next: got beats=%0d beat3=(%0d,%0d) last6=%0d required 7 (2,1) 1",
               capCnt, capRow[3], capCol[3], capLast[6]);
    end
  endtask

  task automatic test_during_output();
    int eR[7] = '{0, 1, 2, 2, 3, 3, 3};
    int eC[7] = '{0, 0, 0, 1, 1, 2, 3};
    bit ok;
    sel = 4;
    mzRows[0] = 16'h0007; mzRows[1] = 16'h0001; mzRows[2] = 16'h0003; mzRows[3] = 16'h000E;
    applyStimulus(4);
    fork
      collect(200);
      begin
        for (int i = 0; i < 200 && !oValid4; i++) @(negedge clk);
        inValid4 = 1'b1; maze4 = 4'b0000;
        repeat (2) @(negedge clk);
        inValid4 = 1'b0;
      end
    join
    ok = !capTimeout && !capGap && capCnt == 7;
    for (int i = 0; i < 7; i++) if (capRow[i] !== eR[i] || capCol[i] !== eC[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL pulse_stream: got beats=%0d gap=%0d beat6=(%0d,%0d) required 7 0 (3,3)",
               capCnt, capGap, capRow[6], capCol[6]);
    end
    @(negedge clk);
    checks++;
    if (mBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pulse_idle: got busy=%0d required 0", mBusy);
    end
  endtask

  task automatic test_reset_mid_output();
    int seen = 0;
    sel = 4;
    for (int i = 0; i < 16; i++) mzRows[i] = 16'h000F;
    applyStimulus(4);
    for (int i = 0; i < 200 && seen < 3; i++) begin
      @(negedge clk);
      if (oValid4) seen++;
    end
    checks++;
    if (seen != 3) begin
      errors++;
      $display("[TB] FAIL rstmid_reach: got beats=%0d required 3", seen);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy4, oValid4, oLast4, noPath4, oRow4, oCol4} !== 8'd0) begin
      errors++;
      $display("[TB] FAIL rstmid_outputs: got %b required 0", {busy4, oValid4, oLast4, noPath4, oRow4, oCol4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4);
    collect(200);
    checks++;
    if (capTimeout || capCnt != 7 || capRow[0] != 0 || capCol[0] != 0 ||
        capRow[3] != 0 || capCol[3] != 3 || capRow[6] != 3 || capCol[6] != 3) begin
      errors++;
      $display("[TB] FAIL rstmid_next: got beats=%0d b0=(%0d,%0d) b3=(%0d,%0d) b6=(%0d,%0d) required 7 (0,0) (0,3) (3,3)",
               capCnt, capRow[0], capCol[0], capRow[3], capCol[3], capRow[6], capCol[6]);
    end
  endtask

  task automatic test_prio_down8();
    sel = 8;
    for (int i = 0; i < 16; i++) mzRows[i] = 16'h00FF;
    applyStimulus(8);
    collect(400);
    checks++;
    if (capTimeout || capGap || capCnt != 15) begin
      errors++;
      $display("[TB] FAIL prio8_len: got beats=%0d timeout=%0d required 15 0", capCnt, capTimeout);
    end
    for (int i = 0; i < 15; i++) begin
      int er = (i < 8) ? i : 7;
      int ec = (i < 8) ? 0 : i - 7;
      checks++;
      if (capRow[i] !== er || capCol[i] !== ec || capLast[i] !== (i == 14)) begin
        errors++;
        $display("[TB] FAIL prio8_beat%0d: got (%0d,%0d) last=%0d required (%0d,%0d) last=%0d",
                 i, capRow[i], capCol[i], capLast[i], er, ec, (i == 14));
      end
    end
`ifdef RIM_SOLVE_CNT_EN
    checks++;
    if (cnt8 !== 16'd15) begin
      errors++;
      $display("[TB] FAIL prio8_cnt: got %0d required 15", cnt8);
    end
`endif
  endtask

  task automatic test_random();
    for (int f = 0; f < 10; f++) begin
      int n = (f % 2 == 0) ? 4 : 8;
      int beats;
      sel = n;
      for (int r = 0; r < 16; r++) mzRows[r] = 16'(($urandom | $urandom) & ((1 << n) - 1));
      if (f < 8) mzRows[0][0] = 1'b1;
      computeExpected(n, (n == 8) ? 1 : 0);
      beats = expNoPath ? 1 : expLen;
      applyStimulus(n);
      collect(400);
      checks++;
      if (capTimeout || capGap || capCnt != beats) begin
        errors++;
        $display("[TB] FAIL rand%0d_len: got beats=%0d timeout=%0d gap=%0d required %0d",
                 f, capCnt, capTimeout, capGap, beats);
      end
      for (int i = 0; i < beats; i++) begin
        int er = expNoPath ? 0 : expRow[i];
        int ec = expNoPath ? 0 : expCol[i];
        checks++;
        if (capRow[i] !== er || capCol[i] !== ec || capNp[i] !== expNoPath || capLast[i] !== (i == beats - 1)) begin
          errors++;
          $display("[TB] FAIL rand%0d_beat%0d: got (%0d,%0d) np=%0d last=%0d required (%0d,%0d) np=%0d last=%0d",
                   f, i, capRow[i], capCol[i], capNp[i], capLast[i], er, ec, expNoPath, (i == beats - 1));
        end
      end
    end
  endtask

  // Bound the whole run in case the design stalls somewhere unexpected.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Run every scenario in order, then report.
  initial begin
    for (int i = 0; i < 16; i++) mzRows[i] = 16'd0;
    test_reset();
    test_all_open();
    test_backtrack();
    test_no_path();
    test_abort();
    test_during_output();
    test_reset_mid_output();
    test_prio_down8();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
